mnist_digit_colorizer: RTL and testbench
========================================

// Module: mnist_digit_colorizer
// PURPOSE
//  Video overlay stage after the MNIST segmentation/classification core. Per pixel, takes the
//  class number (0-9) and a detection count; when the count reaches a threshold it replaces the
//  pixel with a fixed per-digit palette colour, otherwise it passes the source (or binary) pixel.
//  Mode and threshold are runtime registers on a Wishbone slave; one AXI4-Stream in, one out.
// PARAMETERS
//  DATA_WIDTH       8      bits per colour component; tdata is 4*DATA_WIDTH
//  TUSER_WIDTH      1      tuser width; bit0 = start of frame
//  TNUMBER_WIDTH    4      class number width
//  TCOUNT_WIDTH     1      detection count width
//  INIT_PARAM_MODE  2'b10  reset value of MODE register
//  INIT_PARAM_TH    1      reset value of TH register
// PORTS
//  clk               in   1               clock, all logic incl. Wishbone
//  reset             in   1               synchronous, active-low
//  s_axi4s_tuser     in   TUSER_WIDTH     frame start (bit0)
//  s_axi4s_tlast     in   1               end of line
//  s_axi4s_tnumber   in   TNUMBER_WIDTH   class of pixel
//  s_axi4s_tcount    in   TCOUNT_WIDTH    detection count
//  s_axi4s_tdata     in   4*DATA_WIDTH    source pixel {X,R,G,B}, B in [DW-1:0]
//  s_axi4s_tbinary   in   1               binarised source pixel
//  s_axi4s_tvalid/tready  in/out 1        input handshake
//  m_axi4s_tuser/tlast    out  TUSER_WIDTH/1  delayed copies
//  m_axi4s_tdata     out  4*DATA_WIDTH    output pixel
//  m_axi4s_tvalid/tready  out/in 1        output handshake
//  s_wb_adr_i 8 in; s_wb_dat_i 32 in; s_wb_dat_o 32 out; s_wb_we_i 1 in; s_wb_sel_i 4 in;
//  s_wb_stb_i 1 in; s_wb_ack_o 1 out      Wishbone register slave
// BEHAVIOUR
//  Interface: reset reset, synchronous, active-low; clock clk.
//  Reset: m_axi4s_tvalid=0, tuser/tlast/tdata=0; MODE=INIT_PARAM_MODE, TH=INIT_PARAM_TH, shadows same.
//  Registers (word adr): 0x00 CORE_ID RO 32'h4D4E_4331; 0x01 MODE[1:0] RW; 0x02 TH[TCOUNT_WIDTH-1:0] RW;
//   others read 0, writes ignored. Write when stb&we&sel[0]; bits above field width ignored.
//   s_wb_ack_o = s_wb_stb_i (combinational, zero wait); s_wb_dat_o combinational read of live regs.
//  Shadow: active MODE/TH copied from live regs on accepted input beat with tuser[0]=1 (applies from
//   that pixel on); never mid-frame.
//  Pipeline: one register stage, latency 1. s_axi4s_tready = !m_axi4s_tvalid | m_axi4s_tready.
//   Input accepted when s_tvalid&s_tready -> output loaded next edge; m_tvalid cleared when m_tready
//   and no new beat. Output held stable while m_tvalid&!m_tready. No beats dropped or duplicated.
//  Base pixel: MODE[0]=1 -> all components = {DATA_WIDTH{tbinary}}, X=0; else tdata unchanged.
//  Hit = MODE[1] & (tcount >= TH) & (tnumber <= 9); TH=0 -> every valid digit pixel is a hit.
//  Hit pixel: R,G,B from palette, X=0; palette 8-bit values placed in MSBs, LSBs zero (DW>8),
//   or truncated to top DW bits (DW<8).
//   0 000000 | 1 804000 | 2 FF0000 | 3 FF8000 | 4 FFFF00 | 5 00FF00 | 6 0000FF | 7 8000FF
//   8 808080 | 9 FFFFFF   (RRGGBB)
//  tnumber 10..15 -> never hit, base pixel passed.
//  Reset mid-frame: pipeline emptied, registers return to init; next frame starts clean.
// TESTING
//  Reset defaults: read adr0/1/2 -> 4D4E4331, 2, 1; ack same cycle as stb.
//  tdata=00202020, tbinary=0, MODE=2, TH=1, tnumber=3, tcount=1 -> m_tdata=00FF8000; tcount=0 -> 00202020.
//  MODE=3, tcount=0, tbinary=1 -> 00FFFFFF; tbinary=0 -> 00000000; tnumber=12, tcount=1 -> base pixel.
//  Write MODE=0 mid-frame -> no change until next tuser beat, then all pixels pass tdata.
//  Random m_tready backpressure over 160x120 frame -> 19200 beats out, order/tlast/tuser preserved.
//  Assert reset low for 1 cycle mid-frame -> m_tvalid=0 next cycle, regs reinitialised.

Source files
------------

// File: rtl/mnist_digit_colorizer.sv
// mnist_digit_colorizer: overlays a per-digit palette colour on pixels whose detection count reaches a threshold.
module mnist_digit_colorizer #(
  parameter int DATA_WIDTH = 8,
  parameter int TUSER_WIDTH = 1,
  parameter int TNUMBER_WIDTH = 4,
  parameter int TCOUNT_WIDTH = 1,
  parameter logic [1:0] INIT_PARAM_MODE = 2'b10,
  parameter logic [TCOUNT_WIDTH-1:0] INIT_PARAM_TH = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
  input  logic                     s_axi4s_tlast,
  input  logic [TNUMBER_WIDTH-1:0] s_axi4s_tnumber,
  input  logic [TCOUNT_WIDTH-1:0]  s_axi4s_tcount,
  input  logic [4*DATA_WIDTH-1:0]  s_axi4s_tdata,
  input  logic                     s_axi4s_tbinary,
  input  logic                     s_axi4s_tvalid,
  output logic                     s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
  output logic                     m_axi4s_tlast,
  output logic [4*DATA_WIDTH-1:0]  m_axi4s_tdata,
  output logic                     m_axi4s_tvalid,
  input  logic                     m_axi4s_tready,
  input  logic [7:0]               s_wb_adr_i,
  input  logic [31:0]              s_wb_dat_i,
  output logic [31:0]              s_wb_dat_o,
  input  logic                     s_wb_we_i,
  input  logic [3:0]               s_wb_sel_i,
  input  logic                     s_wb_stb_i,
  output logic                     s_wb_ack_o
);
  localparam logic [239:0] PALETTE = {24'hFFFFFF, 24'h808080, 24'h8000FF, 24'h0000FF, 24'h00FF00,
                                      24'hFFFF00, 24'hFF8000, 24'hFF0000, 24'h804000, 24'h000000};
  logic [1:0] reg_mode, act_mode, cur_mode;
  logic [TCOUNT_WIDTH-1:0] reg_th, act_th, cur_th;
  logic sof, accept, hit, wr;
  logic [23:0] pal;
  logic [4*DATA_WIDTH-1:0] base, pix;
  logic unused;
  // Palette entries are 8-bit; keep their MSBs and zero-fill or truncate to DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] fit(input logic [7:0] v);
    logic [DATA_WIDTH+7:0] t;
    t = {v, {DATA_WIDTH{1'b0}}};
    return t[DATA_WIDTH+7:8];
  endfunction
  assign s_axi4s_tready = !m_axi4s_tvalid || m_axi4s_tready;
  assign accept = s_axi4s_tvalid && s_axi4s_tready;
  assign sof = s_axi4s_tuser[0];
  // A frame-start beat already uses the freshly latched live registers.
  assign cur_mode = sof ? reg_mode : act_mode;
  assign cur_th = sof ? reg_th : act_th;
  assign wr = s_wb_stb_i && s_wb_we_i && s_wb_sel_i[0];
  assign s_wb_ack_o = s_wb_stb_i;
  assign unused = ^{s_wb_sel_i[3:1], s_wb_dat_i, s_axi4s_tuser};
  always_comb begin
    s_wb_dat_o = s_wb_adr_i == 8'h00 ? 32'h4D4E_4331 :
                 s_wb_adr_i == 8'h01 ? {30'd0, reg_mode} :
                 s_wb_adr_i == 8'h02 ? 32'(reg_th) : 32'd0;
    pal = 24'(PALETTE >> (24 * 32'(s_axi4s_tnumber)));
    hit = cur_mode[1] && s_axi4s_tcount >= cur_th && 32'(s_axi4s_tnumber) <= 32'd9;
    base = cur_mode[0] ? {{DATA_WIDTH{1'b0}}, {3*DATA_WIDTH{s_axi4s_tbinary}}} : s_axi4s_tdata;
    pix = hit ? {{DATA_WIDTH{1'b0}}, fit(pal[23:16]), fit(pal[15:8]), fit(pal[7:0])} : base;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_axi4s_tvalid <= 1'b0;
      m_axi4s_tuser <= '0;
      m_axi4s_tlast <= 1'b0;
      m_axi4s_tdata <= '0;
      reg_mode <= INIT_PARAM_MODE;
      act_mode <= INIT_PARAM_MODE;
      reg_th <= INIT_PARAM_TH;
      act_th <= INIT_PARAM_TH;
    end else begin
      if (s_axi4s_tready) m_axi4s_tvalid <= s_axi4s_tvalid;
      if (accept) begin
        m_axi4s_tuser <= s_axi4s_tuser;
        m_axi4s_tlast <= s_axi4s_tlast;
        m_axi4s_tdata <= pix;
      end
      if (accept && sof) begin
        act_mode <= reg_mode;
        act_th <= reg_th;
      end
      if (wr && s_wb_adr_i == 8'h01) reg_mode <= s_wb_dat_i[1:0];
      if (wr && s_wb_adr_i == 8'h02) reg_th <= s_wb_dat_i[TCOUNT_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_mnist_digit_colorizer.sv
// tb_mnist_digit_colorizer: randomized stream/register checks against a palette reference model.
module tb_mnist_digit_colorizer;
  localparam logic [23:0] PAL [10] = '{24'h000000, 24'h804000, 24'hFF0000, 24'hFF8000, 24'hFFFF00,
                                       24'h00FF00, 24'h0000FF, 24'h8000FF, 24'h808080, 24'hFFFFFF};
  logic clk = 0, reset = 0;
  logic [0:0] s_axi4s_tuser = 0, m_axi4s_tuser;
  logic s_axi4s_tlast = 0, m_axi4s_tlast;
  logic [3:0] s_axi4s_tnumber = 0;
  logic [0:0] s_axi4s_tcount = 0;
  logic [31:0] s_axi4s_tdata = 0, m_axi4s_tdata;
  logic s_axi4s_tbinary = 0, s_axi4s_tvalid = 0, s_axi4s_tready;
  logic m_axi4s_tvalid, m_axi4s_tready = 1;
  logic [7:0] s_wb_adr_i = 0;
  logic [31:0] s_wb_dat_i = 0, s_wb_dat_o;
  logic s_wb_we_i = 0, s_wb_stb_i = 0, s_wb_ack_o;
  logic [3:0] s_wb_sel_i = 0;
  int errors = 0, checks = 0;
  typedef struct {
    logic user, last, cnt, bin;
    logic [3:0] num;
    logic [31:0] data, exp;
  } beat_t;
  beat_t q[$];
  logic [1:0] live_mode = 2, act_mode = 2;
  logic live_th = 1, act_th = 1;

  always #5 clk = ~clk;

  mnist_digit_colorizer dut (
    .clk(clk), .reset(reset),
    .s_axi4s_tuser(s_axi4s_tuser), .s_axi4s_tlast(s_axi4s_tlast), .s_axi4s_tnumber(s_axi4s_tnumber),
    .s_axi4s_tcount(s_axi4s_tcount), .s_axi4s_tdata(s_axi4s_tdata), .s_axi4s_tbinary(s_axi4s_tbinary),
    .s_axi4s_tvalid(s_axi4s_tvalid), .s_axi4s_tready(s_axi4s_tready),
    .m_axi4s_tuser(m_axi4s_tuser), .m_axi4s_tlast(m_axi4s_tlast), .m_axi4s_tdata(m_axi4s_tdata),
    .m_axi4s_tvalid(m_axi4s_tvalid), .m_axi4s_tready(m_axi4s_tready),
    .s_wb_adr_i(s_wb_adr_i), .s_wb_dat_i(s_wb_dat_i), .s_wb_dat_o(s_wb_dat_o), .s_wb_we_i(s_wb_we_i),
    .s_wb_sel_i(s_wb_sel_i), .s_wb_stb_i(s_wb_stb_i), .s_wb_ack_o(s_wb_ack_o)
  );

  function automatic logic [31:0] ref_pix(logic [1:0] m, logic th, logic [3:0] n, logic c, logic [31:0] d, logic b);
    if (m[1] && c >= th && n <= 9) return {8'h00, PAL[n]};
    if (m[0]) return b ? 32'h00FF_FFFF : 32'h0;
    return d;
  endfunction

  task automatic push(logic u, logic l, logic [3:0] n, logic c, logic [31:0] d, logic b, logic [31:0] exp);
    beat_t bt;
    bt.user = u; bt.last = l; bt.num = n; bt.cnt = c; bt.data = d; bt.bin = b; bt.exp = exp;
    q.push_back(bt);
  endtask

  task automatic add_beat(logic u, logic l, logic [3:0] n, logic c, logic [31:0] d, logic b);
    if (u) begin act_mode = live_mode; act_th = live_th; end
    push(u, l, n, c, d, b, ref_pix(act_mode, act_th, n, c, d, b));
  endtask

  task automatic add_directed(logic u, logic [3:0] n, logic c, logic [31:0] d, logic b, logic [31:0] exp);
    if (u) begin act_mode = live_mode; act_th = live_th; end
    push(u, 1'b0, n, c, d, b, exp);
  endtask

  task automatic add_random(int n, logic sof);
    for (int i = 0; i < n; i++)
      add_beat(sof && i == 0, i == n - 1, 4'($urandom_range(15)), 1'($urandom), $urandom, 1'($urandom));
  endtask

  task automatic wb_write(logic [7:0] a, logic [31:0] d);
    s_wb_adr_i = a; s_wb_dat_i = d; s_wb_we_i = 1; s_wb_sel_i = 4'hF; s_wb_stb_i = 1;
    @(posedge clk); #1;
    s_wb_stb_i = 0; s_wb_we_i = 0;
    if (a == 8'h01) live_mode = d[1:0];
    if (a == 8'h02) live_th = d[0];
  endtask

  task automatic wb_read(logic [7:0] a, output logic [31:0] d, output logic ack);
    s_wb_adr_i = a; s_wb_we_i = 0; s_wb_stb_i = 1;
    #1;
    d = s_wb_dat_o; ack = s_wb_ack_o;
    s_wb_stb_i = 0;
  endtask

  task automatic run_stream(int rdy_pct, int idle_pct);
    int n;
    n = q.size();
    fork
      begin
        int w;
        logic acc;
        for (int i = 0; i < n; i++) begin
          while ($urandom_range(99) < idle_pct) begin s_axi4s_tvalid = 0; @(posedge clk); #1; end
          s_axi4s_tuser = q[i].user; s_axi4s_tlast = q[i].last; s_axi4s_tnumber = q[i].num;
          s_axi4s_tcount = q[i].cnt; s_axi4s_tdata = q[i].data; s_axi4s_tbinary = q[i].bin;
          s_axi4s_tvalid = 1;
          w = 0;
          forever begin
            @(negedge clk); acc = s_axi4s_tready;
            @(posedge clk); #1;
            if (acc) break;
            if (++w > 1000) begin
              checks++; errors++;
              $display("FAIL input_accept beat %0d: tready stuck low, required 1", i);
              break;
            end
          end
        end
        s_axi4s_tvalid = 0;
      end
      begin
        int j, cyc;
        logic held;
        logic [33:0] hv;
        j = 0; cyc = 0; held = 0; hv = 0;
        while (j < n && cyc < n * 10 + 200) begin
          @(posedge clk); #1;
          m_axi4s_tready = $urandom_range(99) < rdy_pct;
          @(negedge clk); cyc++;
          if (held) begin
            checks++;
            if (!m_axi4s_tvalid || {m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata} !== hv) begin
              errors++;
              $display("FAIL hold_stable beat %0d: got v=%0b %h required v=1 %h", j, m_axi4s_tvalid,
                       {m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata}, hv);
            end
          end
          if (m_axi4s_tvalid && m_axi4s_tready) begin
            checks++;
            if ({m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata} !== {q[j].user, q[j].last, q[j].exp}) begin
              errors++;
              $display("FAIL out_beat %0d: got user=%0b last=%0b data=%h required user=%0b last=%0b data=%h",
                       j, m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata, q[j].user, q[j].last, q[j].exp);
            end
            j++; held = 0;
          end else begin
            held = m_axi4s_tvalid;
            hv = {m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata};
          end
        end
        checks++;
        if (j != n) begin
          errors++;
          $display("FAIL beat_count: got %0d required %0d", j, n);
        end
      end
    join
    m_axi4s_tready = 1;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (m_axi4s_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle: m_tvalid=%0b required 0", m_axi4s_tvalid);
    end
    q.delete();
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic a;
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m_axi4s_tvalid, m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b u=%0b l=%0b d=%h required all 0", m_axi4s_tvalid,
               m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata);
    end
    reset = 1;
    @(posedge clk); #1;
    wb_read(8'h00, d, a);
    checks++;
    if (d !== 32'h4D4E_4331 || a !== 1'b1) begin errors++; $display("FAIL core_id: got %h ack=%0b required 4d4e4331 ack=1", d, a); end
    wb_read(8'h01, d, a);
    checks++;
    if (d !== 32'd2 || a !== 1'b1) begin errors++; $display("FAIL mode_init: got %h ack=%0b required 2 ack=1", d, a); end
    wb_read(8'h02, d, a);
    checks++;
    if (d !== 32'd1 || a !== 1'b1) begin errors++; $display("FAIL th_init: got %h ack=%0b required 1 ack=1", d, a); end
    wb_read(8'h07, d, a);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL unmapped_read: got %h required 0", d); end
    checks++;
    if (s_wb_ack_o !== 1'b0) begin errors++; $display("FAIL ack_idle: got %0b required 0", s_wb_ack_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_palette;
    wb_write(8'h01, 32'd2);
    wb_write(8'h02, 32'd1);
    add_directed(1, 4'd3, 1'b1, 32'h0020_2020, 1'b0, 32'h00FF_8000);
    add_directed(0, 4'd3, 1'b0, 32'h0020_2020, 1'b0, 32'h0020_2020);
    add_directed(0, 4'd7, 1'b1, 32'hAA12_3456, 1'b1, 32'h0080_00FF);
    add_directed(0, 4'd13, 1'b1, 32'hAA12_3456, 1'b1, 32'hAA12_3456);
    add_random(200, 0);
    run_stream(100, 0);
  endtask

  task automatic test_binary;
    wb_write(8'h01, 32'hFFFF_FFF3);
    add_directed(1, 4'd5, 1'b0, 32'h1234_5678, 1'b1, 32'h00FF_FFFF);
    add_directed(0, 4'd5, 1'b0, 32'h1234_5678, 1'b0, 32'h0000_0000);
    add_directed(0, 4'd12, 1'b1, 32'h1234_5678, 1'b1, 32'h00FF_FFFF);
    add_directed(0, 4'd1, 1'b1, 32'h1234_5678, 1'b0, 32'h0080_4000);
    add_random(100, 0);
    run_stream(60, 20);
  endtask

  task automatic test_th_zero;
    logic [31:0] d;
    logic a;
    wb_write(8'h02, 32'hFFFF_FFFE);
    wb_read(8'h02, d, a);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL th_write_width: got %h required 0", d); end
    wb_write(8'h01, 32'd2);
    add_directed(1, 4'd9, 1'b0, 32'h0011_2233, 1'b0, 32'h00FF_FFFF);
    add_directed(0, 4'd10, 1'b0, 32'h0011_2233, 1'b0, 32'h0011_2233);
    add_random(80, 0);
    run_stream(80, 10);
    wb_write(8'h02, 32'd1);
  endtask

  task automatic test_midframe;
    wb_write(8'h01, 32'd2);
    add_random(20, 1);
    run_stream(90, 10);
    wb_write(8'h01, 32'd0);
    add_directed(0, 4'd4, 1'b1, 32'h0033_3333, 1'b0, 32'h00FF_FF00);
    add_random(20, 0);
    run_stream(90, 10);
    add_directed(1, 4'd4, 1'b1, 32'h0033_3333, 1'b0, 32'h0033_3333);
    add_random(20, 0);
    run_stream(90, 10);
  endtask

  task automatic test_back_to_back;
    wb_write(8'h01, 32'd2);
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        add_beat(x == 0 && y == 0, x == 159, 4'($urandom_range(15)), 1'($urandom), $urandom, 1'($urandom));
    run_stream(70, 5);
  endtask

  task automatic test_reset_midframe;
    logic [31:0] d;
    logic a;
    m_axi4s_tready = 0;
    s_axi4s_tuser = 1; s_axi4s_tlast = 0; s_axi4s_tnumber = 2; s_axi4s_tcount = 1;
    s_axi4s_tdata = 32'h0055_5555; s_axi4s_tvalid = 1;
    @(posedge clk); #1;
    s_axi4s_tvalid = 0;
    checks++;
    if (m_axi4s_tvalid !== 1'b1) begin errors++; $display("FAIL preload_valid: got %0b required 1", m_axi4s_tvalid); end
    wb_write(8'h01, 32'd1);
    wb_write(8'h02, 32'd0);
    reset = 0;
    @(posedge clk); #1;
    reset = 1;
    checks++;
    if (m_axi4s_tvalid !== 1'b0 || m_axi4s_tdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_midframe: got v=%0b d=%h required v=0 d=0", m_axi4s_tvalid, m_axi4s_tdata);
    end
    wb_read(8'h01, d, a);
    checks++;
    if (d !== 32'd2) begin errors++; $display("FAIL mode_reinit: got %h required 2", d); end
    wb_read(8'h02, d, a);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL th_reinit: got %h required 1", d); end
    live_mode = 2; act_mode = 2; live_th = 1; act_th = 1;
    m_axi4s_tready = 1;
    @(posedge clk); #1;
    add_random(30, 1);
    run_stream(90, 10);
  endtask

  initial begin
    test_reset;
    test_palette;
    test_binary;
    test_th_zero;
    test_midframe;
    test_back_to_back;
    test_reset_midframe;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
